ik_swift_param_writer: RTL and testbench

Host-side bus transmitter for the IKSwift configuration register map. It accepts 36-bit fixed-point configuration words (targets, DH parameters, joint-type vector) on a valid/ready stream. Each word is serialized into the byte-wide chipselect/write/address/writedata sequence that the IKSwift memory interface decodes. It sits between the bridge/DMA front end and the IKSwift memory interface, and is the writer for that interface's byte-addressed map.

---
 rtl/ik_swift_param_writer_if.sv | 23 ++
 rtl/ik_swift_param_writer.sv | 116 +++++++++++
 tb/tb_ik_swift_param_writer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ik_swift_param_writer_if.sv
// Word stream and byte-wide IKSwift bus bundled for the configuration writer.
// The master side is the bridge/DMA front end; the slave side is the writer itself.
interface ik_swift_param_writer_if;
    logic        word_valid;
    logic        word_ready;
    logic [4:0]  word_index;
    logic [35:0] word_data;
    logic        waitrequest;
    logic        chipselect;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;

    modport master (
        output word_valid, word_index, word_data, waitrequest,
        input  word_ready, chipselect, write, address, writedata
    );

    modport slave (
        input  word_valid, word_index, word_data, waitrequest,
        output word_ready, chipselect, write, address, writedata
    );
endinterface

// File: rtl/ik_swift_param_writer.sv
// Serializes 36-bit IKSwift configuration words into byte writes on the
// IKSwift memory interface (five bytes per word, one byte for joint_type).
module ik_swift_param_writer (
    input  logic                         clk,
    input  logic                         reset,
    ik_swift_param_writer_if.slave       bus,
    output logic                         busy,
    output logic                         err,
    input  logic                         clr_err,
    output logic [7:0]                   words_done
);

    typedef enum logic {IDLE, XFER} state_e;

    state_e      state_q, state_d;
    logic [2:0]  bc_q;
    logic        jt_q;
    logic [7:0]  buf_q [4];
    logic        cs_q;
    logic [7:0]  addr_q;
    logic [7:0]  wdata_q;
    logic        err_q;
    logic [7:0]  done_q;

    logic        accept;
    logic        legal;
    logic        final_byte;

    function automatic logic [7:0] base_addr(input logic [4:0] idx);
        if (idx <= 5'd5)       return {idx, 3'b000} + 8'd7;
        else if (idx <= 5'd29) return {idx, 3'b000} + 8'd8;
        else                   return 8'd0;
    endfunction

    // Byte k of a full word, most significant nibble first.
    function automatic logic [7:0] word_byte(input logic [35:0] d, input logic [2:0] k);
        case (k)
            3'd0:    return {4'b0000, d[35:32]};
            3'd1:    return d[31:24];
            3'd2:    return d[23:16];
            3'd3:    return d[15:8];
            default: return d[7:0];
        endcase
    endfunction

    assign final_byte = (state_q == XFER) && (bc_q == (jt_q ? 3'd0 : 3'd4)) && !bus.waitrequest;
    assign accept     = bus.word_valid && bus.word_ready;
    assign legal      = accept && (bus.word_index != 5'd31);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (legal) state_d = XFER;
            XFER:    if (final_byte) state_d = legal ? XFER : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.word_ready = !reset && ((state_q == IDLE) || final_byte);
        busy           = (state_q == XFER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q    <= 1'b0;
            addr_q  <= 8'd0;
            wdata_q <= 8'd0;
            bc_q    <= 3'd0;
            jt_q    <= 1'b0;
            done_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            if (legal) begin
                cs_q    <= 1'b1;
                addr_q  <= base_addr(bus.word_index);
                wdata_q <= (bus.word_index == 5'd30) ? {2'b00, bus.word_data[5:0]}
                                                     : word_byte(bus.word_data, 3'd0);
                bc_q    <= 3'd0;
                jt_q    <= (bus.word_index == 5'd30);
            end else if ((state_q == XFER) && !bus.waitrequest) begin
                if (final_byte) begin
                    cs_q <= 1'b0;
                end else begin
                    bc_q    <= bc_q + 3'd1;
                    addr_q  <= addr_q + 8'd1;
                    wdata_q <= buf_q[bc_q[1:0]];
                end
            end
            if (final_byte) done_q <= done_q + 8'd1;
            // Setting takes priority over a simultaneous clear.
            if (accept && (bus.word_index == 5'd31)) err_q <= 1'b1;
            else if (clr_err)                        err_q <= 1'b0;
        end
    end

    // buf_q[k] holds byte k+1 of the accepted word; byte 0 goes straight to the bus.
    always_ff @(posedge clk) begin
        if (legal) begin
            for (int k = 0; k < 4; k++) buf_q[k] <= word_byte(bus.word_data, 3'(k + 1));
        end
    end

    assign bus.chipselect = cs_q;
    assign bus.write      = cs_q;
    assign bus.address    = addr_q;
    assign bus.writedata  = wdata_q;
    assign err            = err_q;
    assign words_done     = done_q;

endmodule

// File: tb/tb_ik_swift_param_writer.sv
// Bench for ik_swift_param_writer: directed scenarios plus random traffic,
// checked every cycle against a queue of expected bus writes.
module tb_ik_swift_param_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr_err;
    logic       busy;
    logic       err;
    logic [7:0] words_done;

    ik_swift_param_writer_if bus ();

    ik_swift_param_writer dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .err        (err),
        .clr_err    (clr_err),
        .words_done (words_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        bit         last;
    } wr_t;

    wr_t        expq[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         chk_en   = 1'b0;
    logic [7:0] exp_done = 8'd0;
    logic       exp_err  = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected bus writes for one accepted word, from the register map rules.
    function automatic void push_word(input logic [4:0] idx, input logic [35:0] d);
        wr_t         e;
        int          base;
        logic [35:0] sh;
        if (idx == 5'd30) begin
            e.a = 8'd0;
            e.d = {2'b00, d[5:0]};
            e.last = 1'b1;
            expq.push_back(e);
        end else begin
            base = (idx < 6) ? 8 * int'(idx) + 7 : 8 * int'(idx) + 8;
            for (int k = 0; k < 5; k++) begin
                sh = d >> (8 * (4 - k));
                e.a = 8'(base + k);
                e.d = sh[7:0];
                e.last = (k == 4);
                expq.push_back(e);
            end
        end
    endfunction

    always @(negedge clk) begin
        bit  exp_ready;
        bit  pending;
        wr_t e;
        if (chk_en) begin
            pending   = (expq.size() != 0);
            exp_ready = !reset && (!pending || (expq.size() == 1 && !bus.waitrequest));
            check_val("word_ready", bus.word_ready, exp_ready);
            check_val("busy", busy, pending);
            check_val("chipselect", bus.chipselect, pending);
            check_val("write", bus.write, pending);
            check_val("words_done", words_done, exp_done);
            check_val("err", err, exp_err);
            if (pending) begin
                check_val("address", bus.address, expq[0].a);
                check_val("writedata", bus.writedata, expq[0].d);
            end
            if (reset) begin
                expq.delete();
                exp_done = 8'd0;
                exp_err  = 1'b0;
            end else begin
                if (pending && !bus.waitrequest) begin
                    e = expq.pop_front();
                    if (e.last) exp_done = exp_done + 8'd1;
                end
                if (exp_ready && bus.word_valid && bus.word_index != 5'd31)
                    push_word(bus.word_index, bus.word_data);
                if (exp_ready && bus.word_valid && bus.word_index == 5'd31) exp_err = 1'b1;
                else if (clr_err)                                           exp_err = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [4:0] idx, input logic [35:0] d);
        bit ok;
        ok = 1'b0;
        bus.word_valid = 1'b1;
        bus.word_index = idx;
        bus.word_data  = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.word_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        bus.word_valid = 1'b0;
        bus.word_index = 5'($urandom);
        bus.word_data  = {4'($urandom), 32'($urandom)};
        if (!ok) check_val("send_timeout", 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (got timeout expected finish)");
        $fatal(1);
    end

    initial begin
        reset           = 1'b1;
        clr_err         = 1'b0;
        bus.word_valid  = 1'b0;
        bus.word_index  = 5'd0;
        bus.word_data   = 36'd0;
        bus.waitrequest = 1'b0;
        idle(3);
        check_val("rst_cs", bus.chipselect, 0);
        check_val("rst_write", bus.write, 0);
        check_val("rst_addr", bus.address, 0);
        check_val("rst_wdata", bus.writedata, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_err", err, 0);
        check_val("rst_done", words_done, 0);
        check_val("rst_ready", bus.word_ready, 0);
        chk_en = 1'b1;
        reset  = 1'b0;

        send(5'd0, 36'h9_1234_5678);
        idle(6);
        check_val("done_single", words_done, 1);
        send(5'd29, 36'hF_FFFF_FFFF);
        idle(6);
        send(5'd6, 36'h1_0203_0405);
        idle(6);
        send(5'd7, 36'hA_BCDE_F012);
        idle(6);
        send(5'd30, 36'h0_0000_002A);
        idle(2);

        send(5'd1, 36'h3_1111_2222);
        send(5'd2, 36'h4_3333_4444);
        idle(12);

        send(5'd3, 36'h5_AA55_C33C);
        idle(2);
        bus.waitrequest = 1'b1;
        idle(3);
        bus.waitrequest = 1'b0;
        idle(6);

        send(5'd31, 36'h7_7777_7777);
        idle(2);
        check_val("err_set", err, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();
        check_val("err_clr", err, 0);

        send(5'd4, 36'h6_DEAD_BEEF);
        idle(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("rst_mid_cs", bus.chipselect, 0);
        check_val("rst_mid_done", words_done, 0);
        send(5'd5, 36'h2_CAFE_F00D);
        idle(6);

        // Joint-type words back-to-back, enough to wrap the completion counter.
        bus.word_valid = 1'b1;
        bus.word_index = 5'd30;
        for (int i = 0; i < 260; i++) begin
            bus.word_data = {4'($urandom), 32'($urandom)};
            tick();
        end
        bus.word_valid = 1'b0;
        idle(3);

        for (int i = 0; i < 600; i++) begin
            bus.word_valid  = 1'($urandom_range(0, 1));
            bus.word_index  = 5'($urandom_range(0, 31));
            bus.word_data   = {4'($urandom), 32'($urandom)};
            bus.waitrequest = ($urandom_range(0, 3) == 0);
            clr_err         = ($urandom_range(0, 15) == 0);
            reset           = ($urandom_range(0, 99) == 0);
            tick();
        end
        bus.word_valid  = 1'b0;
        bus.waitrequest = 1'b0;
        clr_err         = 1'b0;
        reset           = 1'b0;
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
